// File: rtl/periph_frame_master_if.sv
// rtl/periph_frame_master_if.sv - request, serializer and response signals of the frame master
interface periph_frame_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  localparam int FRAME_W = 40 + DATA_W + ADDR_W;

  logic              iStart;
  logic [15:0]       iInstruction;
  logic [ADDR_W-1:0] iAddr;
  logic [DATA_W-1:0] iData;
  logic              iError;
  logic              iTxDone;
  logic              iRxFlag;
  logic              iRetry;
  logic              iWait;
  logic              iReady;
  logic [DATA_W-1:0] iMSGData;

  logic               oTransmit;
  logic               oReady;
  logic               oFail;
  logic               oBusy;
  logic [FRAME_W-1:0] oOutputMsg;
  logic [DATA_W-1:0]  oData;
  logic [7:0]         oRetryCount;

  modport master (
    input  iStart, iInstruction, iAddr, iData, iError,
    input  iTxDone, iRxFlag, iRetry, iWait, iReady, iMSGData,
    output oTransmit, oReady, oFail, oBusy, oOutputMsg, oData, oRetryCount
  );

  modport slave (
    output iStart, iInstruction, iAddr, iData, iError,
    output iTxDone, iRxFlag, iRetry, iWait, iReady, iMSGData,
    input  oTransmit, oReady, oFail, oBusy, oOutputMsg, oData, oRetryCount
  );
endinterface

// File: rtl/periph_frame_master.sv
// rtl/periph_frame_master.sv - frame send / confirm / retry / backoff sequencer with registered outputs
module periph_frame_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT     = 255,
  parameter int WAIT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  periph_frame_master_if.master bus
);
  localparam int FRAME_W = 40 + DATA_W + ADDR_W;
  localparam logic [7:0]  MAX_RETRY_C = 8'((MAX_RETRY > 255) ? 255 : MAX_RETRY);
  localparam logic [31:0] TIMEOUT_C   = 32'(TIMEOUT);
  localparam logic [31:0] WAIT_C      = 32'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_TXWAIT, S_CONFIRM, S_BACKOFF, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        instr_q, instr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic [7:0]         retry_q, retry_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [31:0]        bo_q, bo_d;
  logic               transmit_q, transmit_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic [FRAME_W-1:0] msg_q, msg_d;
  logic [DATA_W-1:0]  odata_q, odata_d;
  logic               take_retry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      retry_q    <= '0;
      tmo_q      <= '0;
      bo_q       <= '0;
      transmit_q <= 1'b0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
      msg_q      <= '0;
      odata_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      bo_q       <= bo_d;
      transmit_q <= transmit_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      msg_q      <= msg_d;
      odata_q    <= odata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    bo_d       = bo_q;
    odata_d    = odata_q;
    take_retry = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          instr_d = bus.iInstruction;
          addr_d  = bus.iAddr;
          data_d  = bus.iData;
          err_d   = bus.iError;
          retry_d = '0;
          odata_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_TXWAIT;
      S_TXWAIT: begin
        if (bus.iTxDone) begin
          tmo_d   = '0;
          state_d = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (bus.iRxFlag) begin
          if (bus.iRetry) begin
            take_retry = 1'b1;
          end else if (bus.iWait) begin
            bo_d    = WAIT_C;
            state_d = S_BACKOFF;
          end else if (bus.iReady) begin
            odata_d = bus.iMSGData;
            state_d = S_DONE;
          end
        end else begin
          // A silent peripheral is treated exactly like an explicit retry request.
          tmo_d = tmo_q + 32'd1;
          if (tmo_q + 32'd1 >= TIMEOUT_C) begin
            take_retry = 1'b1;
          end
        end
      end
      S_BACKOFF: begin
        bo_d = bo_q - 32'd1;
        if (bo_q <= 32'd1) begin
          state_d = S_SEND;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (take_retry) begin
      if (retry_q < MAX_RETRY_C) begin
        retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        state_d = S_SEND;
      end else begin
        odata_d = '0;
        state_d = S_FAIL;
      end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    transmit_d = (state_d == S_SEND);
    ready_d    = (state_d == S_DONE);
    fail_d     = (state_d == S_FAIL);
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_SEND || state_d == S_TXWAIT || state_d == S_CONFIRM) begin
      msg_d = {8'h0F, instr_d, data_d, addr_d, 7'b0, err_d, 8'hF0};
    end else begin
      msg_d = '0;
    end
  end

  assign bus.oTransmit   = transmit_q;
  assign bus.oReady      = ready_q;
  assign bus.oFail       = fail_q;
  assign bus.oBusy       = busy_q;
  assign bus.oOutputMsg  = msg_q;
  assign bus.oData       = odata_q;
  assign bus.oRetryCount = retry_q;
endmodule

// File: tb/tb_periph_frame_master.sv
// tb/tb_periph_frame_master.sv - directed vectors and corner sequences for periph_frame_master
module tb_periph_frame_master;
  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   tx_cnt;
  int   ready_cnt;
  int   fail_cnt;

  periph_frame_master_if #(.DATA_W(32), .ADDR_W(24)) bus ();

  periph_frame_master #(
    .DATA_W(32), .ADDR_W(24), .MAX_RETRY(3), .TIMEOUT(255), .WAIT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [15:0] instr;
    logic [23:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] rsp;
    logic [95:0] frame;
  } vec_t;

  vec_t vecs [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.oTransmit) tx_cnt++;
    if (bus.oReady) ready_cnt++;
    if (bus.oFail) fail_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] instr, input logic [23:0] addr,
                          input logic [31:0] data, input logic err);
    bus.iInstruction = instr;
    bus.iAddr        = addr;
    bus.iData        = data;
    bus.iError       = err;
    bus.iStart       = 1'b1;
    tick();
    bus.iStart       = 1'b0;
  endtask

  // Called with the DUT in SEND; returns one cycle after the response is sampled.
  task automatic respond(input logic r, input logic w, input logic rd, input logic [31:0] md);
    tick();
    bus.iTxDone  = 1'b1;
    tick();
    bus.iTxDone  = 1'b0;
    bus.iRxFlag  = 1'b1;
    bus.iRetry   = r;
    bus.iWait    = w;
    bus.iReady   = rd;
    bus.iMSGData = md;
    tick();
    bus.iRxFlag  = 1'b0;
    bus.iRetry   = 1'b0;
    bus.iWait    = 1'b0;
    bus.iReady   = 1'b0;
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.oTransmit && n < 400);
  endtask

  initial begin
    int n;
    int t0;
    int r0;
    int f0;
    tests = 0; fails = 0; tx_cnt = 0; ready_cnt = 0; fail_cnt = 0;
    vecs[0] = '{16'h0002, 24'h123456, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D,
                96'h0F_0002_DEADBEEF_123456_00_F0};
    vecs[1] = '{16'hABCD, 24'hFFFFFF, 32'h00000000, 1'b1, 32'h12345678,
                96'h0F_ABCD_00000000_FFFFFF_01_F0};
    vecs[2] = '{16'hFFFF, 24'h000000, 32'hFFFFFFFF, 1'b1, 32'h80000001,
                96'h0F_FFFF_FFFFFFFF_000000_01_F0};

    reset = 1'b0;
    bus.iStart = 0; bus.iInstruction = 0; bus.iAddr = 0; bus.iData = 0; bus.iError = 0;
    bus.iTxDone = 0; bus.iRxFlag = 0; bus.iRetry = 0; bus.iWait = 0; bus.iReady = 0;
    bus.iMSGData = 0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("reset_busy", 96'(bus.oBusy), 96'd0);
    chk("reset_tx", 96'(bus.oTransmit), 96'd0);
    chk("reset_msg", bus.oOutputMsg, 96'd0);
    chk("reset_data", 96'(bus.oData), 96'd0);
    chk("reset_retry", 96'(bus.oRetryCount), 96'd0);

    for (int i = 0; i < 3; i++) begin
      t0 = tx_cnt;
      do_start(vecs[i].instr, vecs[i].addr, vecs[i].data, vecs[i].err);
      chk($sformatf("v%0d_msg", i), bus.oOutputMsg, vecs[i].frame);
      chk($sformatf("v%0d_tx", i), 96'(bus.oTransmit), 96'd1);
      chk($sformatf("v%0d_busy", i), 96'(bus.oBusy), 96'd1);
      respond(1'b0, 1'b0, 1'b1, vecs[i].rsp);
      chk($sformatf("v%0d_ready", i), 96'(bus.oReady), 96'd1);
      chk($sformatf("v%0d_data", i), 96'(bus.oData), 96'(vecs[i].rsp));
      chk($sformatf("v%0d_msg_done", i), bus.oOutputMsg, 96'd0);
      tick();
      chk($sformatf("v%0d_ready_off", i), 96'(bus.oReady), 96'd0);
      chk($sformatf("v%0d_idle", i), 96'(bus.oBusy), 96'd0);
      tick(); tick(); tick();
      chk($sformatf("v%0d_data_hold", i), 96'(bus.oData), 96'(vecs[i].rsp));
      chk($sformatf("v%0d_tx_count", i), 96'(tx_cnt - t0), 96'd1);
    end

    // Four retries exhaust MAX_RETRY=3.
    t0 = tx_cnt; r0 = ready_cnt; f0 = fail_cnt;
    do_start(vecs[0].instr, vecs[0].addr, vecs[0].data, vecs[0].err);
    for (int k = 0; k < 4; k++) respond(1'b1, 1'b0, 1'b0, 32'h0);
    chk("retry_fail", 96'(bus.oFail), 96'd1);
    chk("retry_count", 96'(bus.oRetryCount), 96'd3);
    chk("retry_data", 96'(bus.oData), 96'd0);
    tick();
    chk("retry_fail_off", 96'(bus.oFail), 96'd0);
    chk("retry_idle", 96'(bus.oBusy), 96'd0);
    chk("retry_tx_pulses", 96'(tx_cnt - t0), 96'd4);
    chk("retry_fail_pulses", 96'(fail_cnt - f0), 96'd1);
    chk("retry_no_ready", 96'(ready_cnt - r0), 96'd0);

    // Wait response: 16 backoff cycles, resend without counting a retry.
    t0 = tx_cnt;
    do_start(vecs[1].instr, vecs[1].addr, vecs[1].data, vecs[1].err);
    respond(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wait_no_tx", 96'(bus.oTransmit), 96'd0);
    wait_tx(n);
    chk("wait_cycles", 96'(n), 96'd16);
    chk("wait_retry", 96'(bus.oRetryCount), 96'd0);
    chk("wait_msg", bus.oOutputMsg, vecs[1].frame);
    respond(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    chk("wait_done_data", 96'(bus.oData), 96'h0BADF00D);
    chk("wait_tx_pulses", 96'(tx_cnt - t0), 96'd2);
    tick();

    // Silent CONFIRM times out after 255 cycles.
    do_start(vecs[2].instr, vecs[2].addr, vecs[2].data, vecs[2].err);
    tick();
    bus.iTxDone = 1'b1;
    tick();
    bus.iTxDone = 1'b0;
    wait_tx(n);
    chk("timeout_cycles", 96'(n), 96'd255);
    chk("timeout_retry", 96'(bus.oRetryCount), 96'd1);
    respond(1'b0, 1'b0, 1'b1, 32'h5);
    chk("timeout_done", 96'(bus.oReady), 96'd1);
    tick();

    // Retry wins over ready in the same response.
    do_start(vecs[0].instr, vecs[0].addr, vecs[0].data, vecs[0].err);
    respond(1'b1, 1'b0, 1'b1, 32'h77);
    chk("prio_resend", 96'(bus.oTransmit), 96'd1);
    chk("prio_no_ready", 96'(bus.oReady), 96'd0);
    chk("prio_retry", 96'(bus.oRetryCount), 96'd1);
    respond(1'b0, 1'b0, 1'b1, 32'h77);
    chk("prio_done", 96'(bus.oData), 96'h77);
    tick();

    // Flag without a response type is ignored.
    t0 = tx_cnt;
    do_start(vecs[1].instr, vecs[1].addr, vecs[1].data, vecs[1].err);
    tick();
    bus.iTxDone = 1'b1;
    tick();
    bus.iTxDone = 1'b0;
    bus.iRxFlag = 1'b1;
    tick(); tick(); tick();
    chk("noflag_busy", 96'(bus.oBusy), 96'd1);
    chk("noflag_msg", bus.oOutputMsg, vecs[1].frame);
    bus.iReady = 1'b1;
    bus.iMSGData = 32'hA5A5A5A5;
    tick();
    bus.iRxFlag = 1'b0; bus.iReady = 1'b0;
    chk("noflag_done", 96'(bus.oData), 96'hA5A5A5A5);
    chk("noflag_tx", 96'(tx_cnt - t0), 96'd1);
    tick();

    // iStart and input changes while busy do not disturb the latched frame.
    t0 = tx_cnt;
    do_start(vecs[0].instr, vecs[0].addr, vecs[0].data, vecs[0].err);
    tick();
    bus.iInstruction = vecs[1].instr; bus.iAddr = vecs[1].addr;
    bus.iData = vecs[1].data; bus.iError = vecs[1].err; bus.iStart = 1'b1;
    tick();
    chk("busy_start_msg", bus.oOutputMsg, vecs[0].frame);
    bus.iStart = 1'b0;
    bus.iTxDone = 1'b1;
    tick();
    bus.iTxDone = 1'b0;
    chk("busy_start_confirm_msg", bus.oOutputMsg, vecs[0].frame);
    respond(1'b1, 1'b0, 1'b0, 32'h0);
    chk("busy_resend_msg", bus.oOutputMsg, vecs[0].frame);

    // Asynchronous reset while in TXWAIT.
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 96'(bus.oBusy), 96'd0);
    chk("rst_msg", bus.oOutputMsg, 96'd0);
    chk("rst_retry", 96'(bus.oRetryCount), 96'd0);
    tick();
    #3 reset = 1'b1;
    t0 = tx_cnt;
    tick(); tick(); tick(); tick();
    chk("rst_no_tx", 96'(tx_cnt - t0), 96'd0);
    chk("rst_idle", 96'(bus.oBusy), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/periph_frame_master.md
PERIPH_FRAME_MASTER -- requirements
Module: periph_frame_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data payload width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter ADDR_W, default 24, address width in bits (multiple of 8, 8..32).
REQ-003 SHALL have parameter MAX_RETRY, default 3, number of resends allowed after the first transmission.
REQ-004 SHALL have parameter TIMEOUT, default 255, number of CONFIRM cycles without iRxFlag before a timeout.
REQ-005 SHALL have parameter WAIT_CYCLES, default 16, number of backoff cycles after a wait response.
REQ-006 SHALL have clock clk; reset reset, asynchronous, active-low.
REQ-007 SHALL have these ports: clk in 1, clock; reset in 1, async active-low reset.
REQ-008 SHALL have these ports: iStart in 1, request strobe; iInstruction in 16, header; iAddr in ADDR_W; iData in DATA_W; iError in 1, error flag.
REQ-009 SHALL have these ports: iTxDone in 1, serializer finished; iRxFlag in 1, response valid; iRetry, iWait and iReady in 1 each, decoded response type; iMSGData in DATA_W, response data.
REQ-010 SHALL have these ports: oTransmit out 1; oReady out 1; oFail out 1; oBusy out 1; oOutputMsg out FRAME_W; oData out DATA_W; oRetryCount out 8.
REQ-011 FRAME_W SHALL equal 40+DATA_W+ADDR_W.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 States SHALL be IDLE, SEND, TXWAIT, CONFIRM, BACKOFF, DONE and FAIL.
REQ-014 In IDLE, iStart=1 SHALL latch iInstruction, iAddr, iData and iError into internal registers, clear the retry count and go to SEND; the latched request SHALL be used for every resend.
REQ-015 oOutputMsg SHALL be {8'h0F, instr, data, addr, 7'b0, err, 8'hF0}, MSB first, valid from SEND until leaving CONFIRM, and 0 otherwise.
REQ-016 SEND SHALL assert oTransmit for exactly one cycle, then go to TXWAIT.
REQ-017 TXWAIT SHALL wait for iTxDone=1, then go to CONFIRM and clear the timeout counter.
REQ-018 CONFIRM SHALL evaluate responses only when iRxFlag=1, with priority iRetry > iWait > iReady.
REQ-019 In CONFIRM, a retry response SHALL go to SEND and increment the retry count if count < MAX_RETRY; otherwise it SHALL go to FAIL.
REQ-020 In CONFIRM, a wait response SHALL go to BACKOFF, load WAIT_CYCLES and leave the retry count unchanged.
REQ-021 In CONFIRM, a ready response SHALL capture iMSGData into oData and go to DONE.
REQ-022 In CONFIRM, iRxFlag=1 with none of iRetry, iWait or iReady set SHALL be ignored and CONFIRM SHALL be held.
REQ-023 The timeout counter SHALL increment on each CONFIRM cycle without iRxFlag; on reaching TIMEOUT it SHALL be handled as a retry response.
REQ-024 BACKOFF SHALL decrement its counter each cycle and go to SEND when the counter reaches 0, so total BACKOFF dwell is WAIT_CYCLES cycles.
REQ-025 DONE SHALL assert oReady for one cycle, then go to IDLE; oData SHALL hold its value until the next accepted iStart.
REQ-026 FAIL SHALL assert oFail for one cycle, then go to IDLE; oData SHALL be 0.
REQ-027 oBusy SHALL be 1 in every state except IDLE.
REQ-028 iStart SHALL be ignored when not in IDLE.
REQ-029 oRetryCount SHALL show the current retry count and saturate at 255.
REQ-030 iTxDone in any state other than TXWAIT SHALL be ignored.

Reset
REQ-031 reset=0 SHALL immediately force IDLE and set all outputs, counters and latched registers to 0, including during mid-transaction; no oTransmit pulse SHALL follow reset release without a new iStart.

Verification
REQ-032 iStart with instr=0x0002, data=0xDEADBEEF, addr=0x123456, err=0 -> oOutputMsg=0x0F_0002_DEADBEEF_123456_00_F0, a 1-cycle oTransmit; then iTxDone followed by iRxFlag+iReady with iMSGData=0xCAFEF00D -> oData=0xCAFEF00D and a 1-cycle oReady.
REQ-033 Four consecutive retry responses with MAX_RETRY=3 -> exactly 4 oTransmit pulses, oRetryCount=3, a 1-cycle oFail and no oReady.
REQ-034 A wait response -> no oTransmit for 16 cycles, then a resend with oRetryCount unchanged at 0.
REQ-035 No iRxFlag for 255 cycles in CONFIRM -> a resend with oRetryCount=1.
REQ-036 iRxFlag with iRetry=1 and iReady=1 in the same cycle -> a resend, not DONE.
REQ-037 reset asserted in TXWAIT -> outputs 0 and IDLE; iStart pulses and input changes while busy -> a frame built from the originally latched values.
